// File: rtl/fpu_seq_pkg.sv
// Shared types and constants for the FPU operation sequencer.
// Covers the controller state encoding, the op_mode codes and the rd_data status bit layout.
package fpu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_BEGIN,
    S_WAIT,
    S_STORE,
    S_CLEAR,
    S_DONE
  } state_t;

  localparam logic [1:0] MODE_ADD       = 2'b00;
  localparam logic [1:0] MODE_SUB       = 2'b01;
  localparam logic [1:0] MODE_ALT       = 2'b10;
  localparam logic [1:0] MODE_PER_ENTRY = 2'b11;

  // Status bits sit directly above the W-bit result field.
  localparam int unsigned RD_UNDERFLOW_OFS = 0;
  localparam int unsigned RD_OVERFLOW_OFS  = 1;
  localparam int unsigned RD_TIMEOUT_OFS   = 2;

  function automatic logic select_op(input logic [1:0] mode, input logic idx_lsb,
                                     input logic entry_op);
    case (mode)
      MODE_ADD:       return 1'b0;
      MODE_SUB:       return 1'b1;
      MODE_ALT:       return idx_lsb;
      MODE_PER_ENTRY: return entry_op;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fpu_seq_mem.sv
// Simple dual-port RAM: one synchronous write port and one registered read port.
module fpu_seq_mem #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [0:(1 << DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Array contents are never cleared; only the read register is reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data <= '0;
    else      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Batch sequencer driving one FPU add/subtract unit through its beg_FSM/ready/rst_FSM handshake.
// Operand pairs are loaded by the host, and each result is stored with its status bits in a result buffer.
module fpu_op_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int unsigned W          = 32,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned TIMEOUT    = 200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [W-1:0]          wr_x,
  input  logic [W-1:0]          wr_y,
  input  logic                  wr_op,
  input  logic [DEPTH_LOG2:0]   num_ops,
  input  logic [1:0]            op_mode,
  input  logic [1:0]            r_mode_cfg,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [DEPTH_LOG2:0]   ops_done,
  output logic [DEPTH_LOG2:0]   timeouts,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [W+2:0]          rd_data,
  output logic                  beg_FSM,
  output logic                  rst_FSM,
  output logic [W-1:0]          Data_X,
  output logic [W-1:0]          Data_Y,
  output logic                  add_subt,
  output logic [1:0]            r_mode,
  input  logic                  ready,
  input  logic                  overflow_flag,
  input  logic                  underflow_flag,
  input  logic [W-1:0]          final_result_ieee
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned CW = DEPTH_LOG2 + 1;

  state_t                state, state_nxt;
  logic [DEPTH_LOG2-1:0] index, index_nxt;
  logic [TW-1:0]         timer;
  logic [CW-1:0]         num_q;
  logic [1:0]            mode_q;
  logic                  abort_q;
  logic                  launch;
  logic                  stop_now;
  logic [W+2:0]          hold_word;
  logic [2*W:0]          op_rd;

  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign done     = (state == S_DONE);
  assign beg_FSM  = (state == S_BEGIN);
  assign rst_FSM  = (state == S_CLEAR);
  assign stop_now = abort_q || abort;

  always_comb begin
    state_nxt = state;
    index_nxt = index;
    launch    = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          launch    = 1'b1;
          index_nxt = '0;
          state_nxt = (num_ops == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD:  state_nxt = S_BEGIN;
      S_BEGIN: state_nxt = S_WAIT;
      S_WAIT: begin
        if (ready || (timer == TW'(TIMEOUT - 1))) state_nxt = S_STORE;
      end
      S_STORE: state_nxt = S_CLEAR;
      S_CLEAR: begin
        if (stop_now || ({1'b0, index} == num_q - CW'(1))) begin
          state_nxt = S_DONE;
        end else begin
          index_nxt = index + 1'b1;
          state_nxt = S_LOAD;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      index     <= '0;
      timer     <= '0;
      num_q     <= '0;
      mode_q    <= MODE_ADD;
      r_mode    <= '0;
      abort_q   <= 1'b0;
      aborted   <= 1'b0;
      ops_done  <= '0;
      timeouts  <= '0;
      Data_X    <= '0;
      Data_Y    <= '0;
      add_subt  <= 1'b0;
      hold_word <= '0;
    end else begin
      state <= state_nxt;
      index <= index_nxt;
      if (launch) begin
        num_q    <= num_ops;
        mode_q   <= op_mode;
        r_mode   <= r_mode_cfg;
        ops_done <= '0;
        timeouts <= '0;
        aborted  <= 1'b0;
        abort_q  <= 1'b0;
      end else if (busy && abort) begin
        abort_q <= 1'b1;
      end
      case (state)
        S_LOAD: begin
          Data_X   <= op_rd[2*W:W+1];
          Data_Y   <= op_rd[W:1];
          add_subt <= select_op(mode_q, index[0], op_rd[0]);
        end
        S_BEGIN: timer <= '0;
        S_WAIT: begin
          // ready wins over an expiring timer.
          if (ready) begin
            hold_word                       <= '0;
            hold_word[W-1:0]                <= final_result_ieee;
            hold_word[W+RD_OVERFLOW_OFS]    <= overflow_flag;
            hold_word[W+RD_UNDERFLOW_OFS]   <= underflow_flag;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            hold_word                       <= '0;
            hold_word[W+RD_TIMEOUT_OFS]     <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_STORE: begin
          ops_done <= ops_done + 1'b1;
          if (hold_word[W+RD_TIMEOUT_OFS]) timeouts <= timeouts + 1'b1;
        end
        S_CLEAR: begin
          if (stop_now) aborted <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Operand read address runs on the next index so LOAD sees its entry without an extra cycle.
  fpu_seq_mem #(.WIDTH(2*W+1), .DEPTH_LOG2(DEPTH_LOG2)) u_operands (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en && !busy),
    .wr_addr (wr_addr),
    .wr_data ({wr_x, wr_y, wr_op}),
    .rd_addr (index_nxt),
    .rd_data (op_rd)
  );

  fpu_seq_mem #(.WIDTH(W+3), .DEPTH_LOG2(DEPTH_LOG2)) u_results (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (state == S_STORE),
    .wr_addr (index),
    .wr_data (hold_word),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Scoreboard bench for fpu_op_sequencer with a behavioural FPU responder and a batch-level reference model.
module tb_fpu_op_sequencer;

  localparam int unsigned W   = 32;
  localparam int unsigned DL  = 4;
  localparam int unsigned TMO = 5;
  localparam int unsigned D   = 1 << DL;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [DL-1:0] wr_addr = '0;
  logic [W-1:0]  wr_x = '0, wr_y = '0;
  logic          wr_op = 1'b0;
  logic [DL:0]   num_ops = '0;
  logic [1:0]    op_mode = '0, r_mode_cfg = '0;
  logic          start = 1'b0, abort = 1'b0;
  logic          busy, done, aborted;
  logic [DL:0]   ops_done, timeouts;
  logic [DL-1:0] rd_addr = '0;
  logic [W+2:0]  rd_data;
  logic          beg_FSM, rst_FSM;
  logic [W-1:0]  Data_X, Data_Y;
  logic          add_subt;
  logic [1:0]    r_mode;
  logic          ready = 1'b0, overflow_flag = 1'b0, underflow_flag = 1'b0;
  logic [W-1:0]  final_result_ieee = '0;

  always #5 clk = ~clk;

  fpu_op_sequencer #(.W(W), .DEPTH_LOG2(DL), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
    .wr_op(wr_op), .num_ops(num_ops), .op_mode(op_mode), .r_mode_cfg(r_mode_cfg),
    .start(start), .abort(abort), .busy(busy), .done(done), .aborted(aborted),
    .ops_done(ops_done), .timeouts(timeouts), .rd_addr(rd_addr), .rd_data(rd_data),
    .beg_FSM(beg_FSM), .rst_FSM(rst_FSM), .Data_X(Data_X), .Data_Y(Data_Y),
    .add_subt(add_subt), .r_mode(r_mode), .ready(ready), .overflow_flag(overflow_flag),
    .underflow_flag(underflow_flag), .final_result_ieee(final_result_ieee)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural FPU: result is plain add/subtract, flags derived from the result bits.
  function automatic logic [W+1:0] fpu_calc(logic [W-1:0] x, logic [W-1:0] y, logic sub);
    logic [W-1:0] r;
    r = sub ? (x - y) : (x + y);
    return {^r, r[3], r};
  endfunction

  int lat_glob [256];
  int launch_no = 0;
  int wcnt = 0;
  bit armed = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready <= 1'b0;
      armed <= 1'b0;
    end else if (rst_FSM) begin
      ready <= 1'b0;
      armed <= 1'b0;
    end else if (beg_FSM) begin
      armed <= 1'b1;
      wcnt  <= 1;
      ready <= (lat_glob[launch_no] <= 1);
      {overflow_flag, underflow_flag, final_result_ieee} <= fpu_calc(Data_X, Data_Y, add_subt);
      launch_no <= launch_no + 1;
    end else if (armed) begin
      wcnt  <= wcnt + 1;
      ready <= (wcnt + 1 >= lat_glob[launch_no - 1]);
    end
  end

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         sub;
    logic [1:0]   rm;
  } launch_t;

  launch_t      launch_q[$];
  logic [W+2:0] rd_q[$];
  bit           rd_issue = 1'b0, rd_seen = 1'b0;
  int           beg_cnt = 0, clr_cnt = 0;
  logic [W-1:0] last_x = '0;

  always @(posedge clk) rd_seen <= rd_issue;

  always @(negedge clk) begin
    launch_t e;
    logic [W+2:0] r;
    if (beg_FSM) begin
      beg_cnt++;
      if (launch_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_launch: got beg_FSM with x=%0h expected none", Data_X);
      end else begin
        e = launch_q.pop_front();
        check("launch_x", 64'(Data_X), 64'(e.x));
        check("launch_y", 64'(Data_Y), 64'(e.y));
        check("launch_op", 64'(add_subt), 64'(e.sub));
        check("launch_rmode", 64'(r_mode), 64'(e.rm));
        last_x = Data_X;
      end
    end
    if (rst_FSM) begin
      clr_cnt++;
      check("x_stable_at_clear", 64'(Data_X), 64'(last_x));
    end
    if (rd_seen) begin
      if (rd_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_read: got %0h expected no read", rd_data);
      end else begin
        r = rd_q.pop_front();
        check("rd_data", 64'(rd_data), 64'(r));
      end
    end
  end

  logic [W-1:0] op_x[D], op_y[D];
  logic         op_b[D];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_op(int i, logic [W-1:0] x, logic [W-1:0] y, logic b);
    wr_en = 1'b1; wr_addr = DL'(i); wr_x = x; wr_y = y; wr_op = b;
    tick();
    wr_en = 1'b0;
    op_x[i] = x; op_y[i] = y; op_b[i] = b;
  endtask

  task automatic run_batch(int num, logic [1:0] mode, logic [1:0] rm, int abort_entry, int poke_at);
    int exp_cycles = 0, stored, tmos = 0, abort_n = -1, n = 0, base, lat, w, beg0, clr0;
    logic sub;
    logic [W+2:0] exp_res[D];
    bit exp_abort;
    base      = launch_no;
    exp_abort = (abort_entry >= 0) && (abort_entry < num);
    stored    = exp_abort ? abort_entry + 1 : num;
    for (int i = 0; i < stored; i++) begin
      case (mode)
        2'b00:   sub = 1'b0;
        2'b01:   sub = 1'b1;
        2'b10:   sub = (i % 2) == 1;
        default: sub = op_b[i];
      endcase
      launch_q.push_back('{x: op_x[i], y: op_y[i], sub: sub, rm: rm});
      lat = lat_glob[base + i];
      w   = (lat > int'(TMO)) ? int'(TMO) : lat;
      if (i == abort_entry) abort_n = exp_cycles + 3;
      exp_cycles += 4 + w;
      if (lat > int'(TMO)) begin
        exp_res[i] = {1'b1, {(W+2){1'b0}}};
        tmos++;
      end else begin
        exp_res[i] = {1'b0, fpu_calc(op_x[i], op_y[i], sub)};
      end
    end
    beg0 = beg_cnt; clr0 = clr_cnt;
    num_ops = (DL+1)'(num); op_mode = mode; r_mode_cfg = rm; start = 1'b1;
    tick();
    start = 1'b0;
    forever begin
      @(negedge clk);
      if (done) break;
      n++;
      abort = (n == abort_n);
      if (n == poke_at) begin
        start = 1'b1; num_ops = 1; op_mode = ~mode;
        wr_en = 1'b1; wr_addr = '0; wr_x = ~op_x[0]; wr_y = ~op_y[0]; wr_op = ~op_b[0];
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
      if (n > 3000) begin
        n_checks++; n_fail++;
        $display("FAIL done_wait: got no done after %0d cycles expected %0d", n, exp_cycles);
        break;
      end
    end
    abort = 1'b0; start = 1'b0; wr_en = 1'b0;
    check("batch_cycles", 64'(n), 64'(exp_cycles));
    check("ops_done", 64'(ops_done), 64'(stored));
    check("timeouts", 64'(timeouts), 64'(tmos));
    check("aborted", 64'(aborted), 64'(exp_abort));
    check("busy_at_done", 64'(busy), 64'(0));
    check("beg_pulses", 64'(beg_cnt - beg0), 64'(stored));
    check("clr_pulses", 64'(clr_cnt - clr0), 64'(stored));
    check("launches_left", 64'(launch_q.size()), 64'(0));
    launch_q.delete();
    tick();
    for (int i = 0; i < stored; i++) begin
      rd_addr = DL'(i);
      rd_q.push_back(exp_res[i]);
      rd_issue = 1'b1;
      tick();
    end
    rd_issue = 1'b0;
    tick();
    tick();
    check("reads_left", 64'(rd_q.size()), 64'(0));
    rd_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_aborted", 64'(aborted), 0);
    check("rst_ops_done", 64'(ops_done), 0);
    check("rst_timeouts", 64'(timeouts), 0);
    check("rst_beg", 64'(beg_FSM), 0);
    check("rst_clr", 64'(rst_FSM), 0);
    check("rst_x", 64'(Data_X), 0);
    check("rst_y", 64'(Data_Y), 0);
    check("rst_op", 64'(add_subt), 0);
    check("rst_rmode", 64'(r_mode), 0);
    check("rst_rd_data", 64'(rd_data), 0);
    #20;
    rst = 1'b1;
    tick();

    // 1.0+2.0, 2.0+4.0, ... with a fixed 3-cycle FPU latency
    for (int i = 0; i < 4; i++)
      write_op(i, 32'h3F800000 + (i << 23), 32'h40000000 + (i << 23), 1'b0);
    for (int i = 0; i < 4; i++) lat_glob[launch_no + i] = 3;
    run_batch(4, 2'b00, 2'b00, -1, -1);

    for (int i = 0; i < int'(D); i++) write_op(i, $urandom, $urandom, 1'($urandom));
    for (int i = 0; i < 3; i++) lat_glob[launch_no + i] = $urandom_range(4, 1);
    run_batch(3, 2'b10, 2'b01, -1, -1);

    for (int i = 0; i < 12; i++) lat_glob[launch_no + i] = $urandom_range(7, 1);
    lat_glob[launch_no]     = TMO;
    lat_glob[launch_no + 1] = TMO + 1;
    run_batch(12, 2'b11, 2'b10, -1, -1);

    for (int i = 0; i < 2; i++) lat_glob[launch_no + i] = 1000;
    run_batch(2, 2'b01, 2'b11, -1, -1);

    for (int i = 0; i < 5; i++) lat_glob[launch_no + i] = $urandom_range(4, 1);
    run_batch(5, 2'b00, 2'b01, 1, -1);

    run_batch(0, 2'b00, 2'b00, -1, -1);

    for (int i = 0; i < 4; i++) lat_glob[launch_no + i] = $urandom_range(6, 1);
    run_batch(4, 2'b11, 2'b01, -1, 3);
    for (int i = 0; i < 2; i++) lat_glob[launch_no + i] = $urandom_range(5, 1);
    run_batch(2, 2'b11, 2'b10, -1, -1);

    // asynchronous reset during the first WAIT of a batch
    lat_glob[launch_no] = 10;
    launch_q.push_back('{x: op_x[0], y: op_y[0], sub: 1'b1, rm: 2'b11});
    num_ops = 4; op_mode = 2'b01; r_mode_cfg = 2'b11; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 20 && !beg_FSM; n++) @(negedge clk);
    check("beg_before_reset", 64'(beg_FSM), 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 0);
    check("mid_rst_done", 64'(done), 0);
    check("mid_rst_beg", 64'(beg_FSM), 0);
    check("mid_rst_clr", 64'(rst_FSM), 0);
    check("mid_rst_x", 64'(Data_X), 0);
    check("mid_rst_rmode", 64'(r_mode), 0);
    check("mid_rst_rd_data", 64'(rd_data), 0);
    launch_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) lat_glob[launch_no + i] = $urandom_range(7, 1);
    run_batch(6, 2'b10, 2'b11, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_op_sequencer.md
# fpu_op_sequencer

Synthesizable batch sequencer that replaces fixed-delay stimulus driving of the FPU add/subtract unit. It holds up to 2**DEPTH_LOG2 operand pairs, launches each through the FPU's beg_FSM/ready/rst_FSM handshake, and stores each result with overflow, underflow and timeout status in a result buffer. It sits between a host load/readback port and one FPU_Add_Subtract_Function instance, parametrised for single or double precision.

## Interface
- W, 32: operand/result width (32 or 64)
- DEPTH_LOG2, 10: log2 of buffer depth
- TIMEOUT, 200: max WAIT cycles per operation before abandoning it (≥2)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- wr_en  in  1  write operand entry (ignored while busy)
- wr_addr  in  DEPTH_LOG2  operand entry index
- wr_x, wr_y  in  W  operand pair
- wr_op  in  1  per-entry op bit (0 add, 1 subtract)
- num_ops  in  DEPTH_LOG2+1  entries to run, sampled on start
- op_mode  in  2  00 all add, 01 all subtract, 10 alternate (starting with add), 11 per-entry wr_op
- r_mode_cfg  in  2  rounding mode, sampled on start
- start  in  1  one-cycle pulse; ignored unless in IDLE or DONE
- abort  in  1  stop batch after current handshake cleanup
- busy  out  1  high in any state except IDLE/DONE
- done  out  1  high in DONE
- aborted  out  1  batch ended by abort; cleared on start
- ops_done  out  DEPTH_LOG2+1  results stored this batch
- timeouts  out  DEPTH_LOG2+1  entries that timed out this batch
- rd_addr  in  DEPTH_LOG2  result index
- rd_data  out  W+3  {timeout, overflow, underflow, result}, one-cycle read latency
- beg_FSM, rst_FSM  out  1  FPU controls
- Data_X, Data_Y  out  W  FPU operands (registered)
- add_subt  out  1  FPU operation
- r_mode  out  2  FPU rounding mode
- ready, overflow_flag, underflow_flag  in  1  FPU status
- final_result_ieee  in  W  FPU result

## Operation
- States: IDLE, LOAD, BEGIN, WAIT, STORE, CLEAR, DONE.
- IDLE/DONE + start: latch num_ops, op_mode, r_mode_cfg; clear ops_done, timeouts, aborted; index=0. If num_ops=0, go to DONE; otherwise go to LOAD.
- LOAD: read operand memory at index. Register Data_X, Data_Y and add_subt at end of cycle, then go to BEGIN.
- add_subt select: mode 00 gives 0; 01 gives 1; 10 gives index[0]; 11 gives the stored op bit.
- BEGIN: beg_FSM=1 for exactly this cycle; timer=0; go to WAIT. ready is not sampled in BEGIN.
- WAIT with ready=1: go to STORE with timeout bit 0. Otherwise timer++.
- WAIT at timer==TIMEOUT-1 with ready=0: go to STORE with timeout bit 1, result field 0, flag bits 0.
- STORE: write result memory[index]; increment ops_done; if timeout, increment timeouts. Go to CLEAR.
- CLEAR: rst_FSM=1 for this cycle.
  - If abort is latched, set aborted and go to DONE.
  - If index==num_ops-1, go to DONE.
  - Otherwise index++ and go to LOAD.
- abort is latched in any busy state and acted on at the next CLEAR. LOAD/BEGIN/WAIT continue to STORE first, so the FPU is always left reset.
- Operand writes while busy are dropped. Result reads are always allowed.
- Simultaneous ready and timer expiry: ready wins, timeout bit 0.

## Timing
- Reset values: all outputs 0; r_mode=00; state IDLE; memories not cleared.
- Per-op cycles = 4 + WAIT cycles. Minimum is 5, with ready in the first WAIT cycle.
- Maximum per op is 4 + TIMEOUT.
- Data_X/Data_Y are stable from BEGIN through CLEAR.
- done rises the cycle after the final CLEAR.
- rd_data is valid the cycle after rd_addr is applied.
- Reset mid-batch returns to IDLE immediately with beg_FSM=rst_FSM=0.

## Structure
- Package fpu_seq_pkg holds:
  - state enum
  - op_mode codes
  - rd_data status bit positions
- Sub-module fpu_seq_mem: simple dual-port RAM (one synchronous write port, one registered read port), parameters WIDTH and DEPTH_LOG2. Two instances:
  - operands: width 2W+1
  - results: width W+3

## Test plan
- Load 4 entries (3F800000+40000000, …), mode 00, ready returned 3 cycles after beg_FSM → 4 results stored, ops_done=4, timeouts=0, each op 7 cycles.
- Mode 10, num_ops=3 → add_subt sequence 0,1,0 observed at BEGIN.
- ready never asserted, TIMEOUT=5, num_ops=2 → both entries have rd_data timeout bit=1 and result 0, timeouts=2, done after 2×9 cycles.
- abort pulsed during WAIT of entry 1 of 5 → that entry stored, rst_FSM pulses once, DONE, aborted=1, ops_done=2.
- num_ops=0 then start → DONE next cycle, beg_FSM never asserted; start during busy ignored.
- rst driven low during WAIT → all outputs 0 asynchronously, IDLE; new batch runs normally.
